// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one W-bit adder among NREQ requesters.
// One operation is in flight at a time, and the result is held until the consumer takes it.
module adder_share_arbiter #(
  parameter int W       = 4,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  output logic [W:0]              res_sum,
  output logic [$clog2(NREQ)-1:0] res_id,
  input  logic                    res_ready,
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [IDW-1:0] ptr_r, ptr_nxt_s, win_s, id_r, res_id_r;
  logic [IDW:0]   pick_s;
  logic           found_s, accept_s, res_valid_r, busy_r;
  logic [W-1:0]   a_r, b_r, win_a_s, win_b_s;
  logic [CW-1:0]  cnt_r;
  logic [W:0]     res_sum_r;

  // The MSB flags a hit; the low bits hold the winning index, scanned upward from p with wrap.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW:0] r;
    int           j;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(p) + i) % NREQ;
      if (!r[IDW] && v[j[IDW-1:0]]) begin
        r = {1'b1, j[IDW-1:0]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign pick_s    = rr_pick(req_valid, ptr_r);
  assign found_s   = pick_s[IDW];
  assign win_s     = pick_s[IDW-1:0];
  assign ptr_nxt_s = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);

  // Operand mux for the current arbitration winner
  always_comb begin
    win_a_s = '0;
    win_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_a_s = (win_s == IDW'(i)) ? req_a[i*W +: W] : win_a_s;
      win_b_s = (win_s == IDW'(i)) ? req_b[i*W +: W] : win_b_s;
    end
  end

  // Next-state and grant decode
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst_n && found_s) begin
          req_ready   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          accept_s    = 1'b1;
          state_nxt_s = COMPUTE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COMPUTE: begin
        if (cnt_r == '0) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = COMPUTE;
        end
      end
      HOLD: begin
        if (res_valid_r && res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, settle counter, result register and pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      id_r        <= '0;
      cnt_r       <= '0;
      res_valid_r <= 1'b0;
      res_sum_r   <= '0;
      res_id_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      if (accept_s) begin
        a_r   <= win_a_s;
        b_r   <= win_b_s;
        id_r  <= win_s;
        cnt_r <= CW'(ADD_LAT - 1);
        ptr_r <= ptr_nxt_s;
      end else begin
        ptr_r <= ptr_r;
      end
      if (state_r == COMPUTE) begin
        if (cnt_r == '0) begin
          res_sum_r   <= {1'b0, a_r} + {1'b0, b_r};
          res_id_r    <= id_r;
          res_valid_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r - CW'(1);
        end
      end else if (state_r == HOLD && res_ready) begin
        res_valid_r <= 1'b0;
      end else begin
        res_valid_r <= res_valid_r;
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_id    = res_id_r;
  assign busy      = busy_r;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: a directed vector table, hand-written corner
// sequences, and randomized traffic checked against a transaction-level reference model.
module tb_adder_share_arbiter;
  localparam int W = 4;
  localparam int NREQ = 4;
  localparam int ADD_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, res_ready, res_valid, busy;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [4:0]  res_sum;
  logic [1:0]  res_id;

  logic        rst3_n, rr3, rv3, busy3;
  logic [3:0]  valid3, ready3;
  logic [15:0] a3v, b3v;
  logic [4:0]  sum3;
  logic [1:0]  id3;

  adder_share_arbiter #(.W(W), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id),
    .res_ready(res_ready), .busy(busy));

  adder_share_arbiter #(.W(W), .NREQ(NREQ), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(valid3), .req_a(a3v), .req_b(b3v),
    .req_ready(ready3), .res_valid(rv3), .res_sum(sum3), .res_id(id3),
    .res_ready(rr3), .busy(busy3));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one op in flight, a countdown to the result, and a held result slot
  int  m_ptr, m_timer, m_psum, m_pid, m_sum, m_id;
  bit  m_inflight, m_resv;
  logic [3:0] last_ready;

  function automatic void m_reset();
    m_ptr = 0; m_timer = 0; m_psum = 0; m_pid = 0;
    m_sum = 0; m_id = 0; m_inflight = 0; m_resv = 0;
  endfunction

  function automatic int m_winner();
    int j;
    if (!rst_n || m_inflight || m_resv) return -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    @(negedge clk);
    w = m_winner();
    last_ready = req_ready;
    chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else if (w >= 0) begin
      m_inflight = 1;
      m_timer = ADD_LAT;
      m_psum = int'(req_a[w*W +: W]) + int'(req_b[w*W +: W]);
      m_pid = w;
      m_ptr = (w + 1) % NREQ;
    end else if (m_inflight) begin
      m_timer--;
      if (m_timer == 0) begin
        m_inflight = 0;
        m_resv = 1;
        m_sum = m_psum;
        m_id = m_pid;
      end
    end else if (m_resv && res_ready) begin
      m_resv = 0;
    end
    #1;
    chk("res_valid", res_valid, m_resv);
    chk("res_sum", res_sum, m_sum);
    chk("res_id", res_id, m_id);
    chk("busy", busy, m_inflight || m_resv);
  endtask

  task automatic tick3();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rr;
    logic [3:0] exp_ready;
    logic       exp_rv;
    logic [4:0] exp_sum;
    logic [1:0] exp_id;
    logic       exp_busy;
  } vec_t;

  vec_t tv [15];

  initial begin
    // Round-robin with all four requesters active, starting from pointer 0
    tv[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 5'd0,  2'd0, 1'b1};
    tv[1]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 5'd3,  2'd0, 1'b1};
    tv[2]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 5'd3,  2'd0, 1'b0};
    tv[3]  = '{4'hF, 1'b1, 4'b0010, 1'b0, 5'd3,  2'd0, 1'b1};
    tv[4]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 5'd7,  2'd1, 1'b1};
    tv[5]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 5'd7,  2'd1, 1'b0};
    tv[6]  = '{4'hF, 1'b1, 4'b0100, 1'b0, 5'd7,  2'd1, 1'b1};
    tv[7]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 5'd11, 2'd2, 1'b1};
    tv[8]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 5'd11, 2'd2, 1'b0};
    tv[9]  = '{4'hF, 1'b1, 4'b1000, 1'b0, 5'd11, 2'd2, 1'b1};
    tv[10] = '{4'hF, 1'b1, 4'b0000, 1'b1, 5'd15, 2'd3, 1'b1};
    tv[11] = '{4'hF, 1'b1, 4'b0000, 1'b0, 5'd15, 2'd3, 1'b0};
    tv[12] = '{4'hF, 1'b1, 4'b0001, 1'b0, 5'd15, 2'd3, 1'b1};
    tv[13] = '{4'hF, 1'b1, 4'b0000, 1'b1, 5'd3,  2'd0, 1'b1};
    tv[14] = '{4'hF, 1'b1, 4'b0000, 1'b0, 5'd3,  2'd0, 1'b0};

    m_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; res_ready = 1'b1;
    rst3_n = 1'b0; valid3 = '0; a3v = '0; b3v = '0; rr3 = 1'b1;

    // Reset with requests pending: no grants and cleared outputs
    step();
    step();
    chk("rst_ready", last_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);

    rst_n = 1'b1;
    req_a = {4'd7, 4'd5, 4'd3, 4'd1};
    req_b = {4'd8, 4'd6, 4'd4, 4'd2};
    for (int i = 0; i < 15; i++) begin
      req_valid = tv[i].valid;
      res_ready = tv[i].rr;
      step();
      chk("tbl_ready", last_ready, tv[i].exp_ready);
      chk("tbl_rv", res_valid, tv[i].exp_rv);
      chk("tbl_sum", res_sum, tv[i].exp_sum);
      chk("tbl_id", res_id, tv[i].exp_id);
      chk("tbl_busy", busy, tv[i].exp_busy);
    end

    // Single request from requester 2
    req_valid = 4'b0100; req_a = 16'h0300; req_b = 16'h0400;
    step();
    chk("single_grant", last_ready, 4'b0100);
    chk("single_busy", busy, 1'b1);
    req_valid = 4'b0000;
    step();
    chk("single_rv", res_valid, 1'b1);
    chk("single_sum", res_sum, 5'd7);
    chk("single_id", res_id, 2'd2);
    step();
    chk("single_done", busy, 1'b0);

    // Carry into the top bit of the sum
    req_valid = 4'b0001; req_a = 16'h000F; req_b = 16'h000F;
    step();
    req_valid = 4'b0000;
    step();
    chk("ovf_sum_ff", res_sum, 5'h1E);
    chk("ovf_id", res_id, 2'd0);
    step();
    req_valid = 4'b0001; req_a = 16'h0008; req_b = 16'h0008;
    step();
    req_valid = 4'b0000;
    step();
    chk("ovf_sum_88", res_sum, 5'h10);
    step();

    // Backpressure: result held while requester 1 waits
    res_ready = 1'b0;
    req_valid = 4'b0001; req_a = {4'd0, 4'd0, 4'd6, 4'd2}; req_b = {4'd0, 4'd0, 4'd1, 4'd3};
    step();
    req_valid = 4'b0010;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", last_ready, 4'b0000);
      chk("bp_rv", res_valid, 1'b1);
      chk("bp_sum", res_sum, 5'd5);
      chk("bp_id", res_id, 2'd0);
    end
    res_ready = 1'b1;
    step();
    chk("bp_consumed", res_valid, 1'b0);
    step();
    chk("bp_next_grant", last_ready, 4'b0010);
    req_valid = 4'b0000;
    step();
    chk("bp_sum1", res_sum, 5'd7);
    step();

    // Randomized traffic, operand churn, backpressure and occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst_n = 1'b1; req_valid = 4'b0000;

    // Three-cycle adder latency and reset during COMPUTE
    tick3();
    tick3();
    chk("d3_rst_rv", rv3, 1'b0);
    chk("d3_rst_busy", busy3, 1'b0);
    rst3_n = 1'b1; valid3 = 4'b1000; a3v = 16'h9000; b3v = 16'h5000;
    @(negedge clk);
    chk("d3_ready", ready3, 4'b1000);
    tick3();
    valid3 = 4'b0000;
    chk("d3_busy", busy3, 1'b1);
    chk("d3_rv_e0", rv3, 1'b0);
    tick3();
    chk("d3_rv_e1", rv3, 1'b0);
    tick3();
    chk("d3_rv_e2", rv3, 1'b0);
    tick3();
    chk("d3_rv_e3", rv3, 1'b1);
    chk("d3_sum", sum3, 5'd14);
    chk("d3_id", id3, 2'd3);
    tick3();
    chk("d3_consumed", rv3, 1'b0);
    chk("d3_idle", busy3, 1'b0);

    valid3 = 4'b0100; a3v = 16'h0100; b3v = 16'h0100;
    @(negedge clk);
    chk("d3_grant2", ready3, 4'b0100);
    tick3();
    valid3 = 4'b0000;
    tick3();
    chk("d3_mid_busy", busy3, 1'b1);
    rst3_n = 1'b0; valid3 = 4'hF;
    @(negedge clk);
    chk("d3_rst_ready", ready3, 4'b0000);
    tick3();
    chk("d3_abort_rv", rv3, 1'b0);
    chk("d3_abort_busy", busy3, 1'b0);
    chk("d3_abort_sum", sum3, 5'd0);
    rst3_n = 1'b1; valid3 = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick3();
      chk("d3_no_result", rv3, 1'b0);
    end
    valid3 = 4'b1001;
    @(negedge clk);
    chk("d3_ptr_reset", ready3, 4'b0001);
    valid3 = 4'b0000;
    tick3();
    chk("d3_dropped", busy3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one W-bit unsigned adder (sum width W+1) between NREQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Per-requester valid/ready operand handshake; single registered result port with valid/ready and requester ID.
- ADD_LAT models adder settle time in whole clock cycles. Sits between operand producers and a shared result consumer in the dataflow exercise set.

Parameters:
- W, 4, operand width; sum is W+1 bits.
- NREQ, 4, number of requesters, 2..8.
- ADD_LAT, 1, cycles spent in COMPUTE before the result registers; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i presents operands.
- req_a  input  NREQ*W  operand a; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  operand b; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; transfer on an edge where req_valid[i] && req_ready[i].
- res_valid  output  1  result available.
- res_sum  output  W+1  a+b of the accepted request.
- res_id  output  clog2(NREQ)  index of the requester that owns res_sum.
- res_ready  input  1  consumer accepts result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, priority pointer=0, res_valid=0, res_sum=0, res_id=0, internal operand/ID/counter registers=0.
  - req_ready=0 while rst_n=0. busy=0.
  - Reset mid-operation aborts the operation; the captured request is discarded and no result is produced.
- States:
  - IDLE -> COMPUTE on acceptance.
  - COMPUTE -> HOLD after ADD_LAT cycles.
  - HOLD -> IDLE when res_valid && res_ready.
- IDLE arbitration:
  - Combinational. Scan from pointer p upward with wrap (p, p+1, ..., NREQ-1, 0, ..., p-1); the first asserted req_valid wins.
  - req_ready is one-hot on the winner, zero otherwise, and zero in every non-IDLE state.
  - At the accepting edge: capture a, b and id of the winner; set counter=ADD_LAT-1; state=COMPUTE; p=(winner+1) mod NREQ.
- COMPUTE:
  - Counter decrements each cycle. At the edge where counter==0: res_sum={1'b0,a}+{1'b0,b}, res_id=id, res_valid=1, state=HOLD.
  - res_valid therefore rises at acceptance edge + ADD_LAT.
- HOLD:
  - res_valid, res_sum and res_id are held stable until the handshake edge. At that edge: res_valid=0, state=IDLE.
  - No new acceptance occurs in that same cycle (req_ready=0 in HOLD).
  - res_sum/res_id keep their last value after res_valid drops.
- Throughput: with res_ready tied high, one operation per ADD_LAT+2 cycles.
- Arithmetic: unsigned with no truncation; the carry appears in res_sum[W]. Example: 4'hF+4'hF=5'h1E.
- Requesters may drop or change req_valid/operands before they are granted. Only values present at the accepting edge are used.
- A requester that keeps req_valid high after its transfer re-enters arbitration at lowest priority. It is not re-served until the others have had a turn.
- A request arriving while busy waits; nothing is lost or queued internally.
- If no req_valid is high in IDLE: remain in IDLE, pointer unchanged.

Test Plan:
- Reset, then single request: req 2 with a=3, b=4 -> req_ready=4'b0100 for 1 cycle; res_valid rises 1 edge after acceptance with res_sum=7, res_id=2; busy high from acceptance until the handshake.
- Overflow: req 0 with a=4'hF, b=4'hF, res_ready=1 -> res_sum=5'h1E, res_id=0; a=4'h8, b=4'h8 -> 5'h10.
- Round-robin: all four req_valid held high with distinct operands, res_ready=1 -> grant order 0,1,2,3,0 with correct sums; one acceptance every 3 cycles (ADD_LAT=1).
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_sum/res_id stable, req_ready=0 throughout, pending req 1 not granted; res_ready=1 -> result consumed, then req 1 granted the following cycle.
- Reset mid-op: rst_n=0 during COMPUTE (ADD_LAT=3) -> next cycle res_valid=0, busy=0, pointer=0; no result is ever emitted for the aborted request.
- ADD_LAT=3, req 3 with a=9, b=5 -> res_valid rises exactly 3 edges after acceptance with res_sum=14, res_id=3.
